risc16_mc_core: RTL and testbench

- Multi-cycle RiSC-16 CPU core with the 8-instruction, 16-bit ISA: 3-bit opcode in [15:13], rA [12:10], rB [9:7], rC [2:0], simm7 [6:0], imm10 [9:0].
- Successor to the single-cycle core, which uses an internal memory array. This core instead reaches a shared external instruction/data memory through a req/ready handshake, so memory may insert wait states.
- Adds reset, halt detection, a parametrised reset vector and address width, and a debug register read port.
- Sits between the testbench/top and a memory model or bus bridge.

---
 rtl/risc16_mc_core_if.sv | 22 ++
 rtl/risc16_mc_core.sv | 176 +++++++++++++++++
 tb/tb_risc16_mc_core.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_mc_core_if.sv
// Memory bus between the RiSC-16 multi-cycle core (master) and a memory model or bridge (slave).
// An access completes on the rising edge where mem_req and mem_ready are both high.
interface risc16_mc_core_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/risc16_mc_core.sv
// Multi-cycle RiSC-16 core: FETCH -> EXEC -> (MEM ->) FETCH over a wait-state capable memory bus.
// Define RISC16_PERF_EN to build the instret/cycles counters; otherwise both read as 0.
module risc16_mc_core #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  risc16_mc_core_if.master    mem,
  output logic                halted,
  output logic [ADDR_W-1:0]   pc_o,
  input  logic [2:0]          dbg_sel,
  output logic [15:0]         dbg_data,
  output logic [31:0]         instret,
  output logic [31:0]         cycles
);
  localparam logic [15:0] HALT_IR = 16'hE071;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_SW, OP_LW, OP_BEQ, OP_JALR
  } op_t;

  state_t state, state_nxt;

  logic [15:0]       ir;
  logic [15:0]       rf [8];
  logic [ADDR_W-1:0] pc, ea, pc_inc, pc_nxt;
  op_t               op;
  logic [2:0]        ra, rb, rc;
  logic [15:0]       va, vb, vc, ea_calc;
  logic signed [15:0] simm;

  logic              ir_ld, ea_ld, pc_we, rf_we;
  logic [2:0]        rf_wa;
  logic [15:0]       rf_wd;
  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [15:0]       bus_wdata;

  function automatic logic signed [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

  assign op      = op_t'(ir[15:13]);
  assign ra      = ir[12:10];
  assign rb      = ir[9:7];
  assign rc      = ir[2:0];
  assign simm    = sext7(ir[6:0]);
  assign va      = (ra == 3'd0) ? 16'h0000 : rf[ra];
  assign vb      = (rb == 3'd0) ? 16'h0000 : rf[rb];
  assign vc      = (rc == 3'd0) ? 16'h0000 : rf[rc];
  assign ea_calc = vb + simm;
  assign pc_inc  = pc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    ir_ld     = 1'b0;
    ea_ld     = 1'b0;
    pc_we     = 1'b0;
    pc_nxt    = pc_inc;
    rf_we     = 1'b0;
    rf_wa     = ra;
    rf_wd     = '0;
    unique case (state)
      S_FETCH: begin
        bus_req  = 1'b1;
        bus_addr = pc;
        if (mem.mem_ready) begin
          ir_ld     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // HALT leaves pc on its own address so pc_o identifies where the core stopped
        if (ir == HALT_IR) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          pc_we     = 1'b1;
          unique case (op)
            OP_ADD:  begin rf_we = 1'b1; rf_wd = vb + vc; end
            OP_ADDI: begin rf_we = 1'b1; rf_wd = vb + simm; end
            OP_NAND: begin rf_we = 1'b1; rf_wd = ~(vb & vc); end
            OP_LUI:  begin rf_we = 1'b1; rf_wd = {ir[9:0], 6'b0}; end
            OP_SW, OP_LW: begin
              pc_we     = 1'b0;
              ea_ld     = 1'b1;
              state_nxt = S_MEM;
            end
            OP_BEQ: begin
              if (va == vb) pc_nxt = pc_inc + simm[ADDR_W-1:0];
            end
            OP_JALR: begin
              rf_we  = 1'b1;
              rf_wd  = 16'(pc_inc);
              pc_nxt = vb[ADDR_W-1:0];
            end
          endcase
        end
      end
      S_MEM: begin
        bus_req   = 1'b1;
        bus_we    = (op == OP_SW);
        bus_addr  = ea;
        bus_wdata = va;
        if (mem.mem_ready) begin
          pc_we     = 1'b1;
          state_nxt = S_FETCH;
          if (op == OP_LW) begin
            rf_we = 1'b1;
            rf_wd = mem.mem_rdata;
          end
        end
      end
      S_HALT: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      ir <= '0;
      ea <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (ir_ld) ir <= mem.mem_rdata;
      if (ea_ld) ea <= ea_calc[ADDR_W-1:0];
      if (pc_we) pc <= pc_nxt;
      if (rf_we && rf_wa != 3'd0) rf[rf_wa] <= rf_wd;
    end
  end

  // Bus outputs are forced low while rst_n is asserted so a pending access drops at once
  assign mem.mem_req   = rst_n & bus_req;
  assign mem.mem_we    = rst_n & bus_we;
  assign mem.mem_addr  = rst_n ? bus_addr  : '0;
  assign mem.mem_wdata = rst_n ? bus_wdata : '0;

  assign halted   = (state == S_HALT);
  assign pc_o     = pc;
  assign dbg_data = (dbg_sel == 3'd0) ? 16'h0000 : rf[dbg_sel];

`ifdef RISC16_PERF_EN
  logic        retire;
  logic [31:0] instret_q, cycles_q;

  assign retire = (state == S_EXEC && ir != HALT_IR && op != OP_SW && op != OP_LW) ||
                  (state == S_MEM && mem.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (retire)            instret_q <= instret_q + 32'd1;
      if (state != S_HALT)   cycles_q  <= cycles_q + 32'd1;
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`else
  assign instret = '0;
  assign cycles  = '0;
`endif
endmodule

// File: tb/tb_risc16_mc_core.sv
// Bench for risc16_mc_core: directed programs plus random straight-line programs checked
// against an instruction-level model; a second ADDR_W=8 instance exercises address wrap.
module tb_risc16_mc_core;
  localparam logic [15:0] HALT = 16'hE071;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_sel = 3'd0;
  logic [2:0] dbg_sel8 = 3'd2;
  logic        halted, halted8;
  logic [15:0] pc_o;
  logic [7:0]  pc8;
  logic [15:0] dbg_data, dbg8;
  logic [31:0] instret, cycles, instret8, cycles8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  risc16_mc_core_if #(.ADDR_W(16)) bus ();
  risc16_mc_core_if #(.ADDR_W(8))  bus8 ();

  risc16_mc_core #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .halted(halted), .pc_o(pc_o),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .instret(instret), .cycles(cycles)
  );

  risc16_mc_core #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mem(bus8), .halted(halted8), .pc_o(pc8),
    .dbg_sel(dbg_sel8), .dbg_data(dbg8), .instret(instret8), .cycles(cycles8)
  );

  // memory model with programmable wait states
  logic [15:0] mem [256];
  logic [15:0] img [256];
  bit          load = 1'b0;
  int          max_wait = 0;
  bit          fix_wait = 1'b0;
  int          wcnt, wait_n;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  assign bus.mem_ready = bus.mem_req && (wcnt >= wait_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= 0;
      wait_n <= fix_wait ? max_wait : 0;
    end else if (bus.mem_req) begin
      if (bus.mem_ready) begin
        wcnt   <= 0;
        wait_n <= fix_wait ? max_wait : int'($urandom_range(32'(max_wait), 0));
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ADDR_W=8 instance: zero-wait ROM
  function automatic logic [15:0] rom8(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h247F;
      8'd1:    return 16'hA881;
      8'd2:    return HALT;
      default: return 16'h5A5A;
    endcase
  endfunction
  assign bus8.mem_rdata = rom8(bus8.mem_addr);
  assign bus8.mem_ready = bus8.mem_req;

  int         n8;
  logic [7:0] addr8;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n8 <= 0;
    end else if (bus8.mem_req && bus8.mem_ready) begin
      if (n8 == 2) addr8 <= bus8.mem_addr;
      n8 <= n8 + 1;
    end
  end

  // bus hold monitor and completed-access log
  bit          pend = 1'b0;
  logic [32:0] p_snap;
  int          hold_err = 0;
  logic [32:0] acc_q [$];

  always @(negedge clk) begin
    if (rst_n && pend && bus.mem_req &&
        ({bus.mem_we, bus.mem_addr, bus.mem_wdata} != p_snap))
      hold_err <= hold_err + 1;
    pend   <= rst_n && bus.mem_req && !bus.mem_ready;
    p_snap <= {bus.mem_we, bus.mem_addr, bus.mem_wdata};
    if (rst_n && bus.mem_req && bus.mem_ready)
      acc_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // instruction encoders
  function automatic logic [15:0] e_rrr(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0000, c};
  endfunction
  function automatic logic [15:0] e_rri(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, a, b, v[6:0]};
  endfunction
  function automatic logic [15:0] e_lui(input logic [2:0] a, input logic [9:0] imm);
    return {3'b011, a, imm};
  endfunction

  // instruction-level reference model
  logic [15:0] m_rf [8];
  logic [15:0] m_mem [256];
  logic [15:0] m_pc;
  int          m_ret;

  task automatic iss_run();
    logic [15:0] ir, va, vb, vc, s, nxt, ea;
    logic [2:0]  a, b;
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_pc  = 16'h0;
    m_ret = 0;
    for (int step = 0; step < 2000; step++) begin
      ir = m_mem[m_pc[7:0]];
      if (ir == HALT) break;
      a  = ir[12:10];
      b  = ir[9:7];
      va = m_rf[a];
      vb = m_rf[b];
      vc = m_rf[ir[2:0]];
      s  = {{9{ir[6]}}, ir[6:0]};
      ea = vb + s;
      nxt = m_pc + 16'd1;
      case (ir[15:13])
        3'd0: m_rf[a] = vb + vc;
        3'd1: m_rf[a] = vb + s;
        3'd2: m_rf[a] = ~(vb & vc);
        3'd3: m_rf[a] = {ir[9:0], 6'b0};
        3'd4: m_mem[ea[7:0]] = va;
        3'd5: m_rf[a] = m_mem[ea[7:0]];
        3'd6: if (va == vb) nxt = m_pc + 16'd1 + s;
        default: begin m_rf[a] = m_pc + 16'd1; nxt = vb; end
      endcase
      m_rf[0] = 16'h0;
      m_pc  = nxt;
      m_ret++;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic run(input int maxw, input bit fix, input int budget,
                     output bit done, output int ncyc, output int base);
    max_wait = maxw;
    fix_wait = fix;
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load  = 1'b0;
    base  = acc_q.size();
    rst_n = 1'b1;
    done  = 1'b0;
    ncyc  = 0;
    while (ncyc < budget && !done) begin
      @(posedge clk);
      ncyc++;
      #1;
      done = halted;
    end
  endtask

  task automatic chk_model(input string tag);
    for (int s = 0; s < 8; s++) begin
      dbg_sel = 3'(s);
      #1;
      chk($sformatf("%s_r%0d", tag, s), {16'h0, dbg_data}, {16'h0, m_rf[s]});
    end
    chk({tag, "_pc"}, {16'h0, pc_o}, {16'h0, m_pc});
  endtask

  task automatic chk_reg(input string tag, input int s, input logic [15:0] exp);
    dbg_sel = 3'(s);
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic chk_perf(input string tag, input int exp_ret, input int exp_cyc);
`ifdef RISC16_PERF_EN
    chk({tag, "_instret"}, instret, 32'(exp_ret));
    chk({tag, "_cycles"}, cycles, 32'(exp_cyc));
`else
    chk({tag, "_instret"}, instret, 32'(exp_ret - exp_ret));
    chk({tag, "_cycles"}, cycles, 32'(exp_cyc - exp_cyc));
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   done, found;
    int   ncyc, base, herr0;
    logic [32:0] e;

    // mid-access reset during a store's wait cycles
    clear_img();
    img[0] = e_rri(3'd1, 3'd1, 3'd0, 9);
    img[1] = e_rri(3'd4, 3'd1, 3'd0, 40);
    img[2] = HALT;
    max_wait = 5;
    fix_wait = 1'b1;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      found = bus.mem_req && bus.mem_we;
    end
    chk("rst_store_seen", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk_reg("rst_r1", 1, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_store_abandoned", 32'(mem[40]), 32'd0);
    chk_perf("rst", 0, 0);

    // ADDI/ADD/HALT, zero wait
    clear_img();
    img[0] = e_rri(3'd1, 3'd1, 3'd0, 5);
    img[1] = e_rri(3'd1, 3'd2, 3'd0, -3);
    img[2] = e_rrr(3'd0, 3'd3, 3'd1, 3'd2);
    img[3] = HALT;
    run(0, 1'b1, 100, done, ncyc, base);
    chk("t1_halted", 32'(done), 32'd1);
    chk("t1_cycles_to_halt", 32'(ncyc), 32'd8);
    chk("t1_first_fetch", 32'(acc_q[base][31:16]), 32'd0);
    chk_reg("t1_r1", 1, 16'h0005);
    chk_reg("t1_r2", 2, 16'hFFFD);
    chk_reg("t1_r3", 3, 16'h0002);
    chk("t1_pc", 32'(pc_o), 32'd3);
    chk_perf("t1", 3, 8);
    chk("w8_halted", 32'(halted8), 32'd1);
    chk("w8_addr", 32'(addr8), 32'd0);
    chk("w8_r2", 32'(dbg8), 32'h247F);
    chk("w8_pc", 32'(pc8), 32'd2);

    // LUI/NAND
    clear_img();
    img[0] = e_lui(3'd1, 10'h3FF);
    img[1] = e_rrr(3'd2, 3'd2, 3'd1, 3'd1);
    img[2] = HALT;
    run(2, 1'b0, 200, done, ncyc, base);
    chk("t2_halted", 32'(done), 32'd1);
    chk_reg("t2_r1", 1, 16'hFFC0);
    chk_reg("t2_r2", 2, 16'h003F);

    // SW then LW with 3 wait cycles per access
    clear_img();
    img[0] = e_rri(3'd1, 3'd1, 3'd0, -21);
    img[1] = e_rri(3'd4, 3'd1, 3'd0, 10);
    img[2] = e_rri(3'd5, 3'd4, 3'd0, 10);
    img[3] = HALT;
    herr0 = hold_err;
    run(3, 1'b1, 200, done, ncyc, base);
    chk("t3_halted", 32'(done), 32'd1);
    chk("t3_latency", 32'(ncyc), 32'd28);
    chk_reg("t3_r4", 4, 16'hFFEB);
    e = acc_q[base + 2];
    chk("t3_sw_access", {15'h0, e[32:16]}, {15'h0, 1'b1, 16'h000A});
    chk("t3_sw_wdata", 32'(e[15:0]), 32'h0000FFEB);
    e = acc_q[base + 4];
    chk("t3_lw_access", {15'h0, e[32:16]}, {15'h0, 1'b0, 16'h000A});
    chk("t3_hold", 32'(hold_err - herr0), 32'd0);

    // BEQ self-loop never halts
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = e_rri(3'd1, 3'(i + 1), 3'd0, i + 1);
    img[4] = e_rri(3'd6, 3'd0, 3'd0, -1);
    run(1, 1'b0, 60, done, ncyc, base);
    chk("t4_loop_running", 32'(done), 32'd0);
    chk("t4_loop_pc", 32'(pc_o), 32'd4);

    // not-taken BEQ, r0 write, JALR (including rA==rB)
    clear_img();
    img[0]  = e_rri(3'd1, 3'd1, 3'd0, 1);
    img[1]  = e_rri(3'd6, 3'd1, 3'd0, 2);
    img[2]  = e_rri(3'd1, 3'd5, 3'd0, 32);
    img[3]  = e_rri(3'd1, 3'd0, 3'd0, 7);
    img[4]  = e_rri(3'd1, 3'd2, 3'd0, 4);
    img[5]  = e_rri(3'd1, 3'd3, 3'd1, 0);
    img[6]  = e_rri(3'd7, 3'd7, 3'd5, 0);
    img[7]  = HALT;
    img[32] = e_rri(3'd1, 3'd6, 3'd0, 3);
    img[33] = e_rri(3'd1, 3'd4, 3'd0, 40);
    img[34] = e_rri(3'd7, 3'd4, 3'd4, 0);
    img[40] = HALT;
    run(2, 1'b0, 400, done, ncyc, base);
    chk("t5_halted", 32'(done), 32'd1);
    chk_reg("t5_r0", 0, 16'h0000);
    chk_reg("t5_r2_bne", 2, 16'h0004);
    chk_reg("t5_r7_link", 7, 16'h0007);
    chk_reg("t5_r6_target", 6, 16'h0003);
    chk_reg("t5_r4_self", 4, 16'h0023);
    chk("t5_pc", 32'(pc_o), 32'h28);
    iss_run();
    chk_model("t5");

    // random straight-line programs with random wait states
    for (int t = 0; t < 12; t++) begin
      clear_img();
      for (int i = 32; i < 64; i++) img[i] = 16'($urandom);
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(6, 0))
          0: img[i] = e_rrr(3'd0, 3'($urandom), 3'($urandom), 3'($urandom));
          1: img[i] = e_rri(3'd1, 3'($urandom), 3'($urandom), int'($urandom_range(127, 0)) - 64);
          2: img[i] = e_rrr(3'd2, 3'($urandom), 3'($urandom), 3'($urandom));
          3: img[i] = e_lui(3'($urandom), 10'($urandom));
          4: img[i] = e_rri(3'd4, 3'($urandom), 3'd0, int'($urandom_range(63, 32)));
          5: img[i] = e_rri(3'd5, 3'($urandom), 3'd0, int'($urandom_range(63, 32)));
          default: img[i] = e_rri(3'd6, 3'($urandom), 3'($urandom), int'($urandom_range(3, 0)));
        endcase
      end
      for (int i = 20; i < 24; i++) img[i] = HALT;
      iss_run();
      run(int'($urandom_range(3, 0)), 1'b0, 1000, done, ncyc, base);
      chk($sformatf("rnd%0d_halted", t), 32'(done), 32'd1);
      chk_model($sformatf("rnd%0d", t));
      for (int i = 32; i < 64; i++)
        chk($sformatf("rnd%0d_mem%0d", t, i), 32'(mem[i]), 32'(m_mem[i]));
`ifdef RISC16_PERF_EN
      chk($sformatf("rnd%0d_instret", t), instret, 32'(m_ret));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
